// File: rtl/nonrestoring_divider_32_bit.sv
// Sequential non-restoring unsigned divider: one quotient bit per cycle, then a remainder fix-up.
// Optional macro DIV_ZERO_SHORTCUT_EN: divisor 0 bypasses the iteration and flags div_by_zero.
module nonrestoring_divider_32_bit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StFix,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [WIDTH:0]    r_q, r_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic [WIDTH-1:0]  d_q, d_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  quot_q, quot_d;
    logic [WIDTH-1:0]  rem_q, rem_d;

    logic [WIDTH:0]    d_ext;
    logic [WIDTH:0]    r_sh;
    logic [WIDTH:0]    r_step;
    logic [WIDTH:0]    r_fix;

`ifdef DIV_ZERO_SHORTCUT_EN
    logic dbz_q, dbz_d;
`endif

    // Partial remainder is 33-bit two's complement; its sign picks add or subtract.
    always_comb begin
        d_ext  = {1'b0, d_q};
        r_sh   = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
        r_step = r_q[WIDTH] ? (r_sh + d_ext) : (r_sh - d_ext);
        r_fix  = r_q[WIDTH] ? (r_q + d_ext) : r_q;
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
`ifdef DIV_ZERO_SHORTCUT_EN
        dbz_d   = dbz_q;
`endif

        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    d_d     = divisor;
                    r_d     = '0;
                    q_d     = dividend;
                    cnt_d   = '0;
                    state_d = StCalc;
`ifdef DIV_ZERO_SHORTCUT_EN
                    if (divisor == '0) begin
                        quot_d  = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                        state_d = StDone;
                    end
`endif
                end else begin
                    state_d = StIdle;
                end
            end
            StCalc: begin
                r_d   = r_step;
                q_d   = {q_q[WIDTH-2:0], ~r_step[WIDTH]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntLast) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                r_d     = r_fix;
                quot_d  = q_q;
                rem_d   = r_fix[WIDTH-1:0];
`ifdef DIV_ZERO_SHORTCUT_EN
                dbz_d   = 1'b0;
`endif
                state_d = StDone;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
        end
    end

`ifdef DIV_ZERO_SHORTCUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            dbz_q <= 1'b0;
        end else begin
            dbz_q <= dbz_d;
        end
    end

    assign div_by_zero = dbz_q;
`else
    assign div_by_zero = 1'b0;
`endif

    assign busy      = (state_q == StCalc) || (state_q == StFix);
    assign done      = (state_q == StDone);
    assign quotient  = quot_q;
    assign remainder = rem_q;

endmodule
